// File: rtl/ttbl_eval_unit_if.sv
// Handshake, configuration and status bundle for the truth-table evaluator.
// The master side drives vectors and table writes; the slave side is the evaluator.
interface ttbl_eval_unit_if #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 8
);
    localparam int ROW_W = 2 ** N_IN;
    localparam int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic             cfg_we;
    logic [SEL_W-1:0] cfg_sel;
    logic [ROW_W-1:0] cfg_row;
    logic             cfg_err;
    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  x;
    logic             out_valid;
    logic             out_ready;
    logic [N_OUT-1:0] f;
    logic [15:0]      eval_cnt;

    modport master (
        output cfg_we, cfg_sel, cfg_row, in_valid, x, out_ready,
        input  cfg_err, in_ready, out_valid, f, eval_cnt
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_row, in_valid, x, out_ready,
        output cfg_err, in_ready, out_valid, f, eval_cnt
    );
endinterface

// File: rtl/ttbl_eval_unit.sv
// Runtime-writable truth-table evaluator: N_OUT functions of N_IN inputs,
// one vector per accepted handshake, all outputs registered behind a single output stage.
module ttbl_eval_unit #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 8,
    parameter logic [N_OUT*(2**N_IN)-1:0] INIT = 32'h176AB5B2
) (
    input logic             clk,
    input logic             rst,
    ttbl_eval_unit_if.slave bus
);
    localparam int ROW_W = 2 ** N_IN;
    localparam int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [SEL_W:0] N_OUT_L = N_OUT[SEL_W:0];

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                       state_q;
    state_t                       state_d;
    logic [N_OUT-1:0][ROW_W-1:0]  tbl_q;
    logic [N_OUT-1:0]             f_p1;
    logic [15:0]                  cnt_q;
    logic                         err_q;
    logic                         ready_c;
    logic                         accept;
    logic                         sel_ok;

    // Bit k of the result is minterm x of function row k.
    function automatic logic [N_OUT-1:0] table_eval(
        input logic [N_OUT-1:0][ROW_W-1:0] t,
        input logic [N_IN-1:0]             v
    );
        logic [N_OUT-1:0] r;
        r = '0;
        for (int k = 0; k < N_OUT; k++) begin
            r[k] = t[k][v];
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        ready_c = 1'b1;
        case (state_q)
            EMPTY: begin
                ready_c = 1'b1;
                if (bus.in_valid) state_d = FULL;
            end
            FULL: begin
                ready_c = bus.out_ready;
                if (bus.out_ready && !bus.in_valid) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    assign accept = bus.in_valid && ready_c;
    assign sel_ok = ({1'b0, bus.cfg_sel} < N_OUT_L);

    // Stage p0 -> p1: lookup reads the table before any same-cycle write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            tbl_q   <= INIT;
            f_p1    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                f_p1  <= table_eval(tbl_q, bus.x);
                cnt_q <= cnt_q + 16'd1;
            end
            if (bus.cfg_we) begin
                if (sel_ok) tbl_q[bus.cfg_sel] <= bus.cfg_row;
                else        err_q              <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = ready_c;
    assign bus.out_valid = (state_q == FULL);
    assign bus.f         = f_p1;
    assign bus.eval_cnt  = cnt_q;
    assign bus.cfg_err   = err_q;
endmodule

// File: tb/tb_ttbl_eval_unit.sv
// Bench for ttbl_eval_unit: directed cases on the default 2-in/8-out build and
// randomized traffic on a 4-in/3-out build against a behavioural table model.
module tb_ttbl_eval_unit;
    localparam logic [47:0] INIT_B = 48'h9C3A_5F01_E7D2;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ttbl_eval_unit_if #(.N_IN(2), .N_OUT(8)) ia ();
    ttbl_eval_unit_if #(.N_IN(4), .N_OUT(3)) ib ();

    ttbl_eval_unit #(.N_IN(2), .N_OUT(8)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ia.slave)
    );

    ttbl_eval_unit #(.N_IN(4), .N_OUT(3), .INIT(INIT_B)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ib.slave)
    );

    // Reference state for the 4-in/3-out build.
    logic [15:0] mtab [3];
    logic        mv;
    logic [2:0]  mf;
    logic [15:0] mcnt;
    logic        merr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        logic [47:0] iv;
        iv = INIT_B;
        for (int k = 0; k < 3; k++) mtab[k] = iv[16*k +: 16];
        mv   = 1'b0;
        mf   = 3'b0;
        mcnt = 16'd0;
        merr = 1'b0;
    endtask

    function automatic logic [2:0] model_eval(input logic [3:0] v);
        logic [2:0] r;
        for (int k = 0; k < 3; k++) r[k] = 1'((mtab[k] >> v) & 16'd1);
        return r;
    endfunction

    initial begin
        logic rdy;
        logic acc;

        rst_a = 1'b1;
        rst_b = 1'b1;
        ia.cfg_we = 1'b0; ia.cfg_sel = '0; ia.cfg_row = '0;
        ia.in_valid = 1'b0; ia.x = '0; ia.out_ready = 1'b1;
        ib.cfg_we = 1'b0; ib.cfg_sel = '0; ib.cfg_row = '0;
        ib.in_valid = 1'b0; ib.x = '0; ib.out_ready = 1'b1;
        step();
        step();
        rst_a = 1'b0;

        chk("rst_out_valid", 32'(ia.out_valid), 32'd0);
        chk("rst_f", 32'(ia.f), 32'd0);
        chk("rst_cnt", 32'(ia.eval_cnt), 32'd0);
        chk("rst_err", 32'(ia.cfg_err), 32'd0);
        chk("rst_in_ready", 32'(ia.in_ready), 32'd1);

        // Back-to-back evaluation of all four minterms
        ia.in_valid = 1'b1;
        ia.x = 2'd0; step(); chk("t1_x0", 32'(ia.f), 32'hCE);
        chk("t1_vld", 32'(ia.out_valid), 32'd1);
        ia.x = 2'd1; step(); chk("t1_x1", 32'(ia.f), 32'h7B);
        ia.x = 2'd2; step(); chk("t1_x2", 32'(ia.f), 32'h64);
        ia.x = 2'd3; step(); chk("t1_x3", 32'(ia.f), 32'h1A);
        chk("t1_cnt", 32'(ia.eval_cnt), 32'd4);
        ia.in_valid = 1'b0;
        step();
        chk("t1_drain_vld", 32'(ia.out_valid), 32'd0);
        chk("t1_f_hold", 32'(ia.f), 32'h1A);

        // Downstream stall
        ia.out_ready = 1'b0;
        ia.in_valid = 1'b1; ia.x = 2'd1;
        step();
        chk("t2_f", 32'(ia.f), 32'h7B);
        ia.x = 2'd2;
        #1;
        chk("t2_stall_ready", 32'(ia.in_ready), 32'd0);
        step();
        chk("t2_hold_f", 32'(ia.f), 32'h7B);
        chk("t2_hold_vld", 32'(ia.out_valid), 32'd1);
        chk("t2_hold_cnt", 32'(ia.eval_cnt), 32'd5);
        ia.out_ready = 1'b1;
        #1;
        chk("t2_release_ready", 32'(ia.in_ready), 32'd1);
        step();
        chk("t2_next_f", 32'(ia.f), 32'h64);
        chk("t2_next_cnt", 32'(ia.eval_cnt), 32'd6);
        ia.in_valid = 1'b0;
        step();
        chk("t2_drain_vld", 32'(ia.out_valid), 32'd0);

        // Same-cycle write and evaluate
        ia.in_valid = 1'b1; ia.x = 2'd3;
        ia.cfg_we = 1'b1; ia.cfg_sel = 3'd0; ia.cfg_row = 4'b1000;
        step();
        chk("t3_prewrite", 32'(ia.f), 32'h1A);
        ia.cfg_we = 1'b0;
        step();
        chk("t3_postwrite", 32'(ia.f), 32'h1B);
        ia.in_valid = 1'b0;
        step();

        // Reset with full output stage and a pending write
        ia.in_valid = 1'b1; ia.x = 2'd0;
        step();
        chk("t5_pre_vld", 32'(ia.out_valid), 32'd1);
        rst_a = 1'b1;
        ia.cfg_we = 1'b1; ia.cfg_sel = 3'd1; ia.cfg_row = 4'b0000; ia.x = 2'd2;
        step();
        chk("t5_vld", 32'(ia.out_valid), 32'd0);
        chk("t5_f", 32'(ia.f), 32'd0);
        chk("t5_cnt", 32'(ia.eval_cnt), 32'd0);
        rst_a = 1'b0;
        ia.cfg_we = 1'b0; ia.x = 2'd1;
        step();
        chk("t5_init_x1", 32'(ia.f), 32'h7B);
        ia.x = 2'd3;
        step();
        chk("t5_init_x3", 32'(ia.f), 32'h1A);

        // Counter wrap
        ia.x = 2'd1;
        for (int n = 0; n < 70000 && ia.eval_cnt != 16'hFFFF; n++) step();
        chk("t6_cnt_ffff", 32'(ia.eval_cnt), 32'hFFFF);
        step();
        chk("t6_cnt_wrap", 32'(ia.eval_cnt), 32'd0);
        chk("t6_f", 32'(ia.f), 32'h7B);
        ia.in_valid = 1'b0;

        // Out-of-range write on the 3-function build
        model_reset();
        rst_b = 1'b0;
        step();
        ib.cfg_we = 1'b1; ib.cfg_sel = 2'd3; ib.cfg_row = 16'hFFFF;
        step();
        chk("t4_err", 32'(ib.cfg_err), 32'd1);
        ib.cfg_we = 1'b0; ib.in_valid = 1'b1; ib.x = 4'd5;
        step();
        chk("t4_table_kept", 32'(ib.f), 32'(model_eval(4'd5)));
        chk("t4_err_sticky", 32'(ib.cfg_err), 32'd1);
        ib.in_valid = 1'b0;
        rst_b = 1'b1;
        step();
        chk("t4_err_clr", 32'(ib.cfg_err), 32'd0);
        rst_b = 1'b0;
        model_reset();

        // Randomized traffic, writes and occasional resets
        for (int i = 0; i < 3000; i++) begin
            step();
            chk("rnd_vld", 32'(ib.out_valid), 32'(mv));
            chk("rnd_f", 32'(ib.f), 32'(mf));
            chk("rnd_cnt", 32'(ib.eval_cnt), 32'(mcnt));
            chk("rnd_err", 32'(ib.cfg_err), 32'(merr));
            rst_b        = ($urandom_range(0, 99) < 2);
            ib.in_valid  = 1'($urandom_range(0, 1));
            ib.out_ready = ($urandom_range(0, 3) != 0);
            ib.x         = 4'($urandom);
            ib.cfg_we    = ($urandom_range(0, 3) == 0);
            ib.cfg_sel   = 2'($urandom_range(0, 3));
            ib.cfg_row   = 16'($urandom);
            #1;
            rdy = !mv || ib.out_ready;
            chk("rnd_in_ready", 32'(ib.in_ready), 32'(rdy));
            if (rst_b) begin
                model_reset();
            end else begin
                acc = ib.in_valid && rdy;
                if (acc) begin
                    mf   = model_eval(ib.x);
                    mv   = 1'b1;
                    mcnt = mcnt + 16'd1;
                end else if (ib.out_ready) begin
                    mv = 1'b0;
                end
                if (ib.cfg_we) begin
                    if (ib.cfg_sel < 2'd3) mtab[ib.cfg_sel] = ib.cfg_row;
                    else                   merr = 1'b1;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
